// File: rtl/spi_bridge_master.sv
// spi_bridge_master: SPI mode-0 master for the byte-stream SPI slave bridge.
// Serialises a payload byte stream onto mosi with ESC/IDLE framing, polls with
// IDLE_CHAR when asked, and unescapes the byte stream received on miso.
module spi_bridge_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter logic [7:0]  IDLE_CHAR = 8'h4A,
  parameter logic [7:0]  ESC_CHAR  = 8'h4D
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       poll,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       nss,
  output logic       busy
);

  localparam logic [7:0] CntLast = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  state_e     state;
  logic [7:0] cnt;        // cycles within the current half-period / phase
  logic [3:0] half;       // half-period index within a byte; even = sclk high
  logic [7:0] hold_data;
  logic       hold_full;
  logic       esc_pend;   // second byte of an escaped pair still to be sent
  logic [7:0] esc_byte;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic       rx_done;    // one-cycle flag: rx_sh holds a complete byte
  logic       rx_esc;
  logic       reload;     // a follow-on byte was loaded at the last falling edge

  logic       cnt_done;
  logic       hold_escapes;
  logic       handshake;
  logic       byte_start;
  logic       consume;
  logic       hold_full_next;
  logic [7:0] src_byte;

  // Byte-source selection and holding-register bookkeeping.
  always_comb begin
    cnt_done     = (cnt == CntLast);
    hold_escapes = (hold_data == IDLE_CHAR) || (hold_data == ESC_CHAR);
    handshake    = tx_valid && tx_ready;
    src_byte     = IDLE_CHAR;
    if (esc_pend) begin
      src_byte = esc_byte;
    end else if (hold_full) begin
      src_byte = hold_escapes ? ESC_CHAR : hold_data;
    end
    // Follow-on bytes are chosen at the 8th falling edge so their MSB is on
    // mosi a full half-period before the next rising edge.
    byte_start = ((state == StIdle) && (hold_full || poll)) ||
                 ((state == StShift) && cnt_done && (half == 4'd14) &&
                  (esc_pend || hold_full || poll));
    consume        = byte_start && (esc_pend || (hold_full && !hold_escapes));
    hold_full_next = hold_full;
    if (handshake) begin
      hold_full_next = 1'b1;
    end else if (consume) begin
      hold_full_next = 1'b0;
    end
  end

  // Holding register, tx_ready and the pending escaped second byte.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      tx_ready  <= 1'b0;
      esc_pend  <= 1'b0;
      esc_byte  <= 8'h00;
    end else begin
      hold_full <= hold_full_next;
      tx_ready  <= ~hold_full_next;
      if (handshake) begin
        hold_data <= tx_data;
      end
      if (byte_start) begin
        if (esc_pend) begin
          esc_pend <= 1'b0;
        end else if (hold_full && hold_escapes) begin
          esc_pend <= 1'b1;
          esc_byte <= hold_data ^ 8'h20;
        end
      end
    end
  end

  // Frame/bit sequencer driving nss, sclk and mosi and sampling miso.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state   <= StIdle;
      cnt     <= 8'h00;
      half    <= 4'h0;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      rx_done <= 1'b0;
      reload  <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      nss     <= 1'b1;
      busy    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        StIdle: begin
          if (byte_start) begin
            state <= StSetup;
            cnt   <= 8'h00;
            nss   <= 1'b0;
            busy  <= 1'b1;
            tx_sh <= src_byte;
            mosi  <= src_byte[7];
          end
        end
        StSetup: begin
          if (cnt_done) begin
            state <= StShift;
            cnt   <= 8'h00;
            half  <= 4'h0;
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso};
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StShift: begin
          if (!cnt_done) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= 8'h00;
            if (half == 4'd15) begin
              if (reload) begin
                half  <= 4'h0;
                sclk  <= 1'b1;
                rx_sh <= {rx_sh[6:0], miso};
              end else begin
                state <= StHold;
              end
            end else begin
              half <= half + 4'd1;
              sclk <= ~sclk;
              if (half[0]) begin
                // Rising edge: sample; the 8th sample completes the byte.
                rx_sh   <= {rx_sh[6:0], miso};
                rx_done <= (half == 4'd13);
              end else if (half == 4'd14) begin
                reload <= byte_start;
                if (byte_start) begin
                  tx_sh <= src_byte;
                  mosi  <= src_byte[7];
                end else begin
                  mosi <= 1'b0;
                end
              end else begin
                tx_sh <= {tx_sh[6:0], 1'b0};
                mosi  <= tx_sh[6];
              end
            end
          end
        end
        StHold: begin
          if (cnt_done) begin
            state <= StGap;
            cnt   <= 8'h00;
            nss   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StGap: begin
          if (cnt_done) begin
            state <= StIdle;
            cnt   <= 8'h00;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Receive unescaping: drop IDLE, latch ESC, un-XOR the escaped byte.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_esc   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_done) begin
        if (rx_esc) begin
          rx_data  <= rx_sh ^ 8'h20;
          rx_valid <= 1'b1;
          rx_esc   <= 1'b0;
        end else if (rx_sh == ESC_CHAR) begin
          rx_esc <= 1'b1;
        end else if (rx_sh != IDLE_CHAR) begin
          rx_data  <= rx_sh;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_bridge_master.sv
// Bench for spi_bridge_master: SPI slave model plus scoreboard queues.
module tb_spi_bridge_master;

  localparam int unsigned ClkDiv = 2;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       poll     = 1'b0;
  logic       miso     = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       sclk;
  logic       mosi;
  logic       nss;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] miso_q[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rx[$];
  logic [7:0] obs_mosi[$];
  logic [7:0] obs_rx[$];
  int om_rd = 0;
  int or_rd = 0;

  always #5 clk = ~clk;

  spi_bridge_master #(
    .CLK_DIV  (ClkDiv),
    .IDLE_CHAR(8'h4A),
    .ESC_CHAR (8'h4D)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .poll         (poll),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .nss          (nss),
    .busy         (busy)
  );

  // Mode-0 slave: loads a byte on nss fall or after each 8th rise, shifts on falls.
  logic [7:0] s_out = 8'h00;
  logic [7:0] s_in = 8'h00;
  int s_cnt = 0;
  int mq_rd = 0;
  logic s_load = 1'b0;
  logic s_prev_nss = 1'b1;
  logic s_prev_sclk = 1'b0;
  always @(nss, sclk) begin
    if (nss === 1'b0 && s_prev_nss === 1'b1) begin
      s_cnt  = 0;
      s_load = 1'b0;
      if (mq_rd < miso_q.size()) begin s_out = miso_q[mq_rd]; mq_rd++; end
      else s_out = 8'h4A;
      miso = s_out[7];
    end else if (nss === 1'b0 && sclk === 1'b1 && s_prev_sclk === 1'b0) begin
      s_in = {s_in[6:0], mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        obs_mosi.push_back(s_in);
        s_cnt  = 0;
        s_load = 1'b1;
      end
    end else if (nss === 1'b0 && sclk === 1'b0 && s_prev_sclk === 1'b1) begin
      if (s_load) begin
        if (mq_rd < miso_q.size()) begin s_out = miso_q[mq_rd]; mq_rd++; end
        else s_out = 8'h4A;
      end else begin
        s_out = {s_out[6:0], 1'b0};
      end
      s_load = 1'b0;
      miso = s_out[7];
    end
    s_prev_nss  = nss;
    s_prev_sclk = sclk;
  end

  // Frame timing monitor and rx collector, sampled on the falling clock edge.
  int low_run = 0, high_run = 0, last_low_len = 0, last_high_len = 0, frames = 0;
  int frame_rises = 0, sclk_low_run = 0, max_low = 0, rx_pulses = 0;
  logic prev_nss = 1'b1, prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (nss !== 1'b0) begin
      if (prev_nss === 1'b0) begin last_low_len = low_run; frames++; end
      high_run++;
      low_run = 0;
    end else begin
      if (prev_nss !== 1'b0) begin
        last_high_len = high_run;
        frame_rises = 0; max_low = 0; sclk_low_run = 0;
      end
      low_run++;
      high_run = 0;
    end
    if (sclk === 1'b1 && prev_sclk !== 1'b1 && nss === 1'b0) begin
      if (frame_rises > 0 && sclk_low_run > max_low) max_low = sclk_low_run;
      frame_rises++;
    end
    sclk_low_run = (sclk === 1'b1) ? 0 : sclk_low_run + 1;
    if (rx_valid === 1'b1) begin obs_rx.push_back(rx_data); rx_pulses++; end
    prev_nss  = nss;
    prev_sclk = sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit drop);
    int n;
    n = 0;
    if (b == 8'h4A || b == 8'h4D) begin
      exp_mosi.push_back(8'h4D);
      exp_mosi.push_back(b ^ 8'h20);
    end else begin
      exp_mosi.push_back(b);
    end
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 4000) begin step(); n++; end
    check("send_ready", 32'(tx_ready), 32'd1);
    step();
    if (drop) tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames < target && n < 20000) begin step(); n++; end
    check("frame_done", 32'(frames >= target), 32'd1);
  endtask

  task automatic verify(input string tag);
    logic [7:0] e;
    check({tag, "_mosi_count"}, 32'(obs_mosi.size() - om_rd), 32'(exp_mosi.size()));
    while (exp_mosi.size() > 0) begin
      e = exp_mosi.pop_front();
      if (om_rd < obs_mosi.size()) begin
        check({tag, "_mosi"}, 32'(obs_mosi[om_rd]), 32'(e));
        om_rd++;
      end
    end
    om_rd = obs_mosi.size();
    check({tag, "_rx_count"}, 32'(obs_rx.size() - or_rd), 32'(exp_rx.size()));
    while (exp_rx.size() > 0) begin
      e = exp_rx.pop_front();
      if (or_rd < obs_rx.size()) begin
        check({tag, "_rx"}, 32'(obs_rx[or_rd]), 32'(e));
        or_rd++;
      end
    end
    or_rd = obs_rx.size();
  endtask

  initial begin
    int f0;
    int n;
    int rp0;
    // Reset values.
    rst_n = 1'b0;
    #1;
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_nss", 32'(nss), 32'd1);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    // Single plain byte, slave answers C3.
    miso_q.push_back(8'hC3);
    exp_rx.push_back(8'hC3);
    f0 = frames;
    rp0 = rx_pulses;
    send(8'h5A, 1'b1);
    check("nss_before_start", 32'(nss), 32'd1);
    step();
    check("nss_after_start", 32'(nss), 32'd0);
    check("busy_in_frame", 32'(busy), 32'd1);
    wait_frames(f0 + 1);
    check("t1_nss_low_len", 32'(last_low_len), 32'(2 * ClkDiv + 16 * ClkDiv));
    check("t1_rises", 32'(frame_rises), 32'd8);
    check("t1_rx_pulses", 32'(rx_pulses - rp0), 32'd1);
    verify("t1");

    // TX escaping: 4A and 4D each become ESC + xor 0x20 in one frame.
    f0 = frames;
    send(8'h4A, 1'b1);
    check("t2_ready_low", 32'(tx_ready), 32'd0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin step(); n++; end
    check("t2_ready_after_pair1", 32'(frame_rises), 32'd8);
    send(8'h4D, 1'b1);
    n = 0;
    while (tx_ready !== 1'b1 && n < 2000) begin step(); n++; end
    check("t2_ready_after_pair2", 32'(frame_rises), 32'd24);
    wait_frames(f0 + 1);
    check("t2_nss_low_len", 32'(last_low_len), 32'(2 * ClkDiv + 64 * ClkDiv));
    verify("t2");

    // RX unescaping while polling.
    miso_q.push_back(8'h4A); miso_q.push_back(8'h4D); miso_q.push_back(8'h6D);
    miso_q.push_back(8'h11); miso_q.push_back(8'h4D); miso_q.push_back(8'h6A);
    for (int i = 0; i < 6; i++) exp_mosi.push_back(8'h4A);
    exp_rx.push_back(8'h4D); exp_rx.push_back(8'h11); exp_rx.push_back(8'h4A);
    f0 = frames;
    poll = 1'b1;
    n = 0;
    while (obs_mosi.size() < om_rd + 6 && n < 5000) begin step(); n++; end
    poll = 1'b0;
    wait_frames(f0 + 1);
    step();
    verify("t3");

    // Back-to-back payload, then a following frame after the gap.
    f0 = frames;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    wait_frames(f0 + 1);
    check("t4_rises", 32'(frame_rises), 32'd24);
    check("t4_sclk_low_max", 32'(max_low), 32'(ClkDiv));
    check("t4_nss_low_len", 32'(last_low_len), 32'(2 * ClkDiv + 48 * ClkDiv));
    send(8'h04, 1'b1);
    n = 0;
    while (nss !== 1'b0 && n < 1000) begin step(); n++; end
    check("t4_gap_min", 32'(last_high_len >= int'(ClkDiv)), 32'd1);
    wait_frames(f0 + 2);
    verify("t4");

    // Reset mid-byte after a lone ESC from the slave.
    miso_q.push_back(8'h4D);
    exp_mosi.push_back(8'h4A);
    rp0 = rx_pulses;
    poll = 1'b1;
    n = 0;
    while (nss !== 1'b0 && n < 1000) begin step(); n++; end
    n = 0;
    while (frame_rises < 12 && n < 1000) begin step(); n++; end
    rst_n = 1'b0;
    #1;
    check("t5_nss", 32'(nss), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rx_data", 32'(rx_data), 32'd0);
    poll = 1'b0;
    step();
    step();
    check("t5_no_rx", 32'(rx_pulses - rp0), 32'd0);
    rst_n = 1'b1;
    step();
    check("t5_ready", 32'(tx_ready), 32'd1);
    verify("t5a");
    miso_q.push_back(8'h20);
    exp_rx.push_back(8'h20);
    f0 = frames;
    send(8'h33, 1'b1);
    wait_frames(f0 + 1);
    verify("t5b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
